// File: rtl/bisection_pkg.sv
// Shared types and constants for the bisection root-search sequencer.
// Fixed point is Q4.15 signed two's complement throughout.
package bisection_pkg;

   localparam int W_DEF      = 20;
   localparam int FRAC_DEF   = 15;
   localparam int ITER_W_DEF = 6;

   localparam logic [W_DEF-1:0] ONE  = 20'h08000;
   localparam logic [W_DEF-1:0] HALF = 20'h04000;

   typedef enum logic [1:0] {
      ST_CONVERGED  = 2'b00,
      ST_MAX_ITER   = 2'b01,
      ST_NO_BRACKET = 2'b10,
      ST_EV_TIMEOUT = 2'b11
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EVAL_A,
      S_EVAL_B,
      S_CHECK,
      S_MID,
      S_EVAL_C,
      S_DECIDE,
      S_DONE
   } state_e;

endpackage

// File: rtl/bisection_seq_if.sv
// Evaluator request/acknowledge port; the sequencer is the master,
// the (arbitrated) polynomial evaluator is the slave.
interface bisection_seq_if
   import bisection_pkg::*;
#(
   parameter int W = W_DEF
);
   logic         ev_req;
   logic [W-1:0] ev_x;
   logic         ev_ack;
   logic [W-1:0] ev_fx;

   modport master (output ev_req, ev_x, input ev_ack, ev_fx);
   modport slave  (input ev_req, ev_x, output ev_ack, ev_fx);
endinterface

// File: rtl/bisection_step.sv
// Combinational bisection datapath: midpoint, bracket update and saturating |f(c)|.
// Keeps all arithmetic out of the control FSM.
module bisection_step
   import bisection_pkg::*;
#(
   parameter int W = W_DEF
)(
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   input  logic signed [W-1:0] fa_i,
   input  logic signed [W-1:0] fc_i,
   output logic signed [W-1:0] a_next_o,
   output logic signed [W-1:0] b_next_o,
   output logic signed [W-1:0] mid_o,
   output logic        [W-1:0] fc_abs_o,
   output logic                repl_b_o
);
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

   logic signed [W:0] sum;

   // One extra bit keeps a+b exact; dropping the LSB is the arithmetic shift.
   assign sum   = {a_i[W-1], a_i} + {b_i[W-1], b_i};
   assign mid_o = sum[W:1];

   assign repl_b_o = fc_i[W-1] != fa_i[W-1];
   assign a_next_o = repl_b_o ? a_i : mid_o;
   assign b_next_o = repl_b_o ? mid_o : b_i;

   assign fc_abs_o = (fc_i == MOST_NEG) ? MOST_POS :
                     fc_i[W-1]          ? W'(-fc_i) : fc_i;
endmodule

// File: rtl/bisection_seq.sv
// Bisection root-search control FSM driving a shared evaluator over a req/ack port.
// Optional ack watchdog enabled by defining BISECT_ACK_TIMEOUT_EN.
module bisection_seq
   import bisection_pkg::*;
#(
   parameter int W           = W_DEF,
   parameter int FRAC        = FRAC_DEF,
   parameter int ITER_W      = ITER_W_DEF,
   parameter int ACK_TIMEOUT = 255
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [W-1:0]      a_init,
   input  logic [W-1:0]      b_init,
   input  logic [W-1:0]      tol,
   input  logic [ITER_W-1:0] max_iter,
   output logic              busy,
   output logic              done,
   output logic [W-1:0]      root,
   output logic [ITER_W-1:0] iter_count,
   output logic [1:0]        status,
   bisection_seq_if.master   ev
);
   state_e            state_q, state_d;
   status_e           status_q, status_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d, c_q, c_d;
   logic [W-1:0]      fa_q, fa_d, fb_q, fb_d, fc_q, fc_d;
   logic [W-1:0]      tol_q, tol_d, root_q, root_d;
   logic [ITER_W-1:0] maxit_q, maxit_d, iter_q, iter_d;
   logic              req;
   logic [W-1:0]      x_mux;

   logic [W-1:0] a_nx, b_nx, mid, fc_abs;
   logic         repl_b;

`ifdef BISECT_ACK_TIMEOUT_EN
   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

   bisection_step #(.W(W)) u_step (
      .a_i      (a_q),
      .b_i      (b_q),
      .fa_i     (fa_q),
      .fc_i     (fc_q),
      .a_next_o (a_nx),
      .b_next_o (b_nx),
      .mid_o    (mid),
      .fc_abs_o (fc_abs),
      .repl_b_o (repl_b)
   );

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      fa_d     = fa_q;
      fb_d     = fb_q;
      fc_d     = fc_q;
      tol_d    = tol_q;
      root_d   = root_q;
      maxit_d  = maxit_q;
      iter_d   = iter_q;
      req      = 1'b0;
      x_mux    = '0;
      case (state_q)
         S_IDLE: if (start) begin
            a_d     = a_init;
            b_d     = b_init;
            tol_d   = tol;
            maxit_d = (max_iter == '0) ? ITER_W'(1) : max_iter;
            iter_d  = '0;
            c_d     = '0;
            state_d = S_EVAL_A;
         end
         S_EVAL_A: begin
            req   = 1'b1;
            x_mux = a_q;
            if (ev.ev_ack) begin
               fa_d    = ev.ev_fx;
               state_d = S_EVAL_B;
            end
         end
         S_EVAL_B: begin
            req   = 1'b1;
            x_mux = b_q;
            if (ev.ev_ack) begin
               fb_d    = ev.ev_fx;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            state_d = S_DONE;
            if (fa_q == '0) begin
               root_d   = a_q;
               status_d = ST_CONVERGED;
            end else if (fb_q == '0) begin
               root_d   = b_q;
               status_d = ST_CONVERGED;
            end else if (fa_q[W-1] == fb_q[W-1]) begin
               root_d   = '0;
               status_d = ST_NO_BRACKET;
            end else begin
               state_d = S_MID;
            end
         end
         S_MID: begin
            c_d     = mid;
            state_d = S_EVAL_C;
         end
         S_EVAL_C: begin
            req   = 1'b1;
            x_mux = c_q;
            if (ev.ev_ack) begin
               fc_d    = ev.ev_fx;
               iter_d  = iter_q + ITER_W'(1);
               state_d = S_DECIDE;
            end
         end
         S_DECIDE: begin
            if (fc_abs <= tol_q) begin
               root_d   = c_q;
               status_d = ST_CONVERGED;
               state_d  = S_DONE;
            end else if (iter_q == maxit_q) begin
               root_d   = c_q;
               status_d = ST_MAX_ITER;
               state_d  = S_DONE;
            end else begin
               a_d     = a_nx;
               b_d     = b_nx;
               if (repl_b) fb_d = fc_q;
               else        fa_d = fc_q;
               state_d = S_MID;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
`ifdef BISECT_ACK_TIMEOUT_EN
      // c_q is cleared on start, so a timeout in EVAL_A/B reports root 0.
      to_cnt_d = '0;
      if (req && !ev.ev_ack) begin
         if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
            root_d   = c_q;
            status_d = ST_EV_TIMEOUT;
            state_d  = S_DONE;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         status_q <= ST_CONVERGED;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         fa_q     <= '0;
         fb_q     <= '0;
         fc_q     <= '0;
         tol_q    <= '0;
         root_q   <= '0;
         maxit_q  <= '0;
         iter_q   <= '0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         fa_q     <= fa_d;
         fb_q     <= fb_d;
         fc_q     <= fc_d;
         tol_q    <= tol_d;
         root_q   <= root_d;
         maxit_q  <= maxit_d;
         iter_q   <= iter_d;
      end
   end

`ifdef BISECT_ACK_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) to_cnt_q <= '0;
      else       to_cnt_q <= to_cnt_d;
   end
`endif

   assign ev.ev_req  = req;
   assign ev.ev_x    = x_mux;
   assign busy       = state_q != S_IDLE;
   assign done       = state_q == S_DONE;
   assign root       = root_q;
   assign iter_count = iter_q;
   assign status     = status_q;
endmodule

// File: tb/tb_bisection_seq.sv
// Randomized self-checking bench for bisection_seq: a behavioural evaluator with
// random ack delays plus a high-level bisection reference model.
module tb_bisection_seq;
   import bisection_pkg::*;

   localparam int W  = 20;
   localparam int IW = 6;
`ifdef BISECT_ACK_TIMEOUT_EN
   localparam int MAX_DLY = 3;
`else
   localparam int MAX_DLY = 7;
`endif
   localparam longint HALF_L = 'h4000;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic          start    = 1'b0;
   logic [W-1:0]  a_init   = '0;
   logic [W-1:0]  b_init   = '0;
   logic [W-1:0]  tol      = '0;
   logic [IW-1:0] max_iter = '0;
   logic          busy, done;
   logic [W-1:0]  root;
   logic [IW-1:0] iter_count;
   logic [1:0]    status;

   logic          ack_drv = 1'b0;
   logic [W-1:0]  fx_drv  = '0;

   bisection_seq_if #(.W(W)) ev_if ();

   assign ev_if.ev_ack = ack_drv;
   assign ev_if.ev_fx  = fx_drv;

   bisection_seq #(.W(W), .FRAC(15), .ITER_W(IW), .ACK_TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .a_init     (a_init),
      .b_init     (b_init),
      .tol        (tol),
      .max_iter   (max_iter),
      .busy       (busy),
      .done       (done),
      .root       (root),
      .iter_count (iter_count),
      .status     (status),
      .ev         (ev_if)
   );

   always #5 clk = ~clk;

   int     total = 0;
   int     bad   = 0;
   int     f_mode = 0;
   longint f_r    = 0;
   int     dly_mode = 0;
   bit     ack_off  = 1'b0;
   int     n_evals  = 0;
   int     x_viol   = 0;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint sx(input longint v);
      logic [W-1:0] t;
      t = v[W-1:0];
      return longint'($signed(t));
   endfunction

   // Function under search; result wrapped to the W-bit bus.
   function automatic longint f_of(input longint x);
      longint y;
      case (f_mode)
         1:       y = f_r - x;
         2:       y = (x < f_r) ? -524288 : 524287;
         default: y = x - f_r;
      endcase
      return sx(y);
   endfunction

   // Evaluator: waits a per-request delay, then acks for one cycle.
   int           wait_cnt = 0;
   int           cur_delay = 0;
   bit           held = 1'b0;
   logic [W-1:0] x_prev = '0;
   always @(negedge clk) begin
      longint fv;
      ack_drv = 1'b0;
      if (reset || !ev_if.ev_req) begin
         wait_cnt = 0;
         held     = 1'b0;
      end else begin
         if (!held) begin
            cur_delay = (dly_mode == 1) ? int'($urandom_range(0, MAX_DLY)) :
                        (dly_mode == 2) ? MAX_DLY : 0;
            wait_cnt  = 0;
         end else if (ev_if.ev_x !== x_prev) begin
            x_viol++;
         end
         x_prev = ev_if.ev_x;
         if (!ack_off && wait_cnt >= cur_delay) begin
            fv      = f_of(longint'($signed(ev_if.ev_x)));
            ack_drv = 1'b1;
            fx_drv  = fv[W-1:0];
            n_evals++;
            held    = 1'b0;
         end else begin
            wait_cnt++;
            held = 1'b1;
         end
      end
   end

   // Reference: plain-arithmetic bisection on integers.
   task automatic model(input longint a_in, input longint b_in, input longint t, input int mi,
                        output logic [W-1:0] m_root, output int m_st, output int m_it,
                        output int m_ne);
      longint a, b, fa, fb, c, fc, absv;
      int     budget;
      a = a_in;
      b = b_in;
      fa = f_of(a);
      fb = f_of(b);
      m_ne = 2;
      m_it = 0;
      m_st = 0;
      m_root = '0;
      if (fa == 0) begin
         m_root = a[W-1:0];
      end else if (fb == 0) begin
         m_root = b[W-1:0];
      end else if ((fa < 0) == (fb < 0)) begin
         m_st = 2;
      end else begin
         budget = (mi == 0) ? 1 : mi;
         while (1) begin
            c  = (a + b) >>> 1;
            fc = f_of(c);
            m_ne++;
            m_it++;
            absv = (fc < 0) ? ((fc == -524288) ? 524287 : -fc) : fc;
            if (absv <= t) begin
               m_root = c[W-1:0];
               break;
            end
            if (m_it == budget) begin
               m_st   = 1;
               m_root = c[W-1:0];
               break;
            end
            if ((fc < 0) != (fa < 0)) b = c;
            else begin
               a  = c;
               fa = fc;
            end
         end
      end
   endtask

   task automatic run(input string name, input longint a, input longint b, input longint t,
                      input int mi, input int fmode, input longint fr, input int dmode,
                      input bit poke, output logic [W-1:0] g_root, output int g_st,
                      output int g_it, output int g_cyc);
      logic [W-1:0] m_root;
      int           m_st, m_it, m_ne, ne0, xv0, k;
      bit           seen;
      f_mode   = fmode;
      f_r      = fr;
      dly_mode = dmode;
      model(a, b, t, mi, m_root, m_st, m_it, m_ne);
      @(negedge clk);
      ne0      = n_evals;
      xv0      = x_viol;
      a_init   = a[W-1:0];
      b_init   = b[W-1:0];
      tol      = t[W-1:0];
      max_iter = IW'(mi);
      start    = 1'b1;
      k        = 1;
      seen     = 1'b0;
      while (k < 3000 && !seen) begin
         @(negedge clk);
         k++;
         start = poke && (k == 4);
         if (poke && k == 4) begin
            a_init   = b[W-1:0];
            b_init   = a[W-1:0];
            tol      = '1;
            max_iter = '0;
         end
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      #1;
      check_eq({name, "/done_seen"}, seen, 1);
      check_eq({name, "/root"}, root, m_root);
      check_eq({name, "/status"}, status, m_st);
      check_eq({name, "/iter"}, iter_count, m_it);
      check_eq({name, "/evals"}, n_evals - ne0, m_ne);
      check_eq({name, "/x_stable"}, x_viol - xv0, 0);
      g_root = root;
      g_st   = status;
      g_it   = iter_count;
      g_cyc  = k;
      @(negedge clk);
      check_eq({name, "/done_pulse"}, done, 0);
      check_eq({name, "/busy_drop"}, busy, 0);
      $display("run %-8s a=%h b=%h tol=%h mi=%0d -> root=%h status=%0d iter=%0d evals=%0d cycles=%0d",
               name, a[W-1:0], b[W-1:0], t[W-1:0], mi, g_root, g_st, g_it, n_evals - ne0, g_cyc);
   endtask

   initial begin
      logic [W-1:0] r;
      int           st, it, cyc, k, ne0, dn;
      longint       ra, rb, rr;

      repeat (3) @(negedge clk);
      check_eq("rst/busy", busy, 0);
      check_eq("rst/done", done, 0);
      check_eq("rst/ev_req", ev_if.ev_req, 0);
      check_eq("rst/root", root, 0);
      check_eq("rst/status", status, 0);
      check_eq("rst/iter", iter_count, 0);
      reset = 1'b0;

      run("exact", 0, 'h8000, 0, 10, 0, HALF_L, 0, 0, r, st, it, cyc);
      check_eq("exact/cycles", cyc, 8);
      check_eq("exact/root_k", r, 'h4000);
      check_eq("exact/iter_k", it, 1);

      run("narrow", 'h3C00, 'h5000, 'h10, 20, 0, HALF_L, 0, 0, r, st, it, cyc);
      check_eq("narrow/root_k", r, 'h4010);
      check_eq("narrow/iter_k", it, 6);
      check_eq("narrow/cycles", cyc, 8 + 3 * 5);

      run("budget", 'h3C00, 'h5000, 0, 3, 0, HALF_L, 0, 0, r, st, it, cyc);
      check_eq("budget/status_k", st, 1);
      check_eq("budget/root_k", r, 'h3E80);
      check_eq("budget/iter_k", it, 3);

      run("nobrkt", 0, 'h8000, 0, 10, 0, -HALF_L, 0, 1, r, st, it, cyc);
      check_eq("nobrkt/status_k", st, 2);
      check_eq("nobrkt/iter_k", it, 0);

      run("abssat", 0, 'h8000, 'h7FFFF, 5, 2, 'h6000, 0, 0, r, st, it, cyc);
      check_eq("abssat/root_k", r, 'h4000);

      run("fa_zero", -4096, 'h8000, 0, 10, 0, -4096, 0, 0, r, st, it, cyc);
      run("fb_zero", -4096, 'h2000, 0, 10, 1, 'h2000, 0, 0, r, st, it, cyc);
      run("mi_zero", 'h3C00, 'h5000, 0, 0, 0, HALF_L, 0, 0, r, st, it, cyc);
      check_eq("mi_zero/iter_k", it, 1);
      check_eq("mi_zero/root_k", r, 'h4600);

      run("rnd_dly", 'h3C00, 'h5000, 'h10, 20, 0, HALF_L, 1, 1, r, st, it, cyc);
      check_eq("rnd_dly/root_k", r, 'h4010);
      check_eq("rnd_dly/iter_k", it, 6);

      for (int i = 0; i < 20; i++) begin
         ra = -longint'($urandom_range(0, 'h20000));
         rb = longint'($urandom_range(1, 'h20000));
         rr = longint'($urandom_range(0, 'h60000)) - 'h30000;
         run("random", ra, rb, longint'($urandom_range(0, 'h40)), int'($urandom_range(0, 25)),
             int'($urandom_range(0, 1)), rr, 1, bit'($urandom_range(0, 1)), r, st, it, cyc);
      end

      // Abort a run in EVAL_C with reset.
      dly_mode = 2;
      f_mode   = 0;
      f_r      = HALF_L;
      @(negedge clk);
      ne0      = n_evals;
      a_init   = 'h3C00;
      b_init   = 'h5000;
      tol      = '0;
      max_iter = 20;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (k < 200 && (n_evals - ne0) < 2) begin @(negedge clk); #1; k++; end
      while (k < 200 && ev_if.ev_req)        begin @(negedge clk); #1; k++; end
      while (k < 200 && !ev_if.ev_req)       begin @(negedge clk); #1; k++; end
      check_eq("rstc/reached_eval_c", (k < 200), 1);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check_eq("rstc/ev_req", ev_if.ev_req, 0);
      check_eq("rstc/busy", busy, 0);
      check_eq("rstc/done", done, 0);
      check_eq("rstc/iter", iter_count, 0);
      reset = 1'b0;
      dn = 0;
      repeat (12) begin @(negedge clk); if (done) dn++; end
      check_eq("rstc/no_done", dn, 0);
      $display("run reset_c aborted in EVAL_C, done pulses after reset=%0d", dn);

`ifdef BISECT_ACK_TIMEOUT_EN
      ack_off = 1'b1;
      @(negedge clk);
      a_init   = '0;
      b_init   = 'h8000;
      tol      = '0;
      max_iter = 5;
      start    = 1'b1;
      k = 1;
      st = 0;
      dn = 0;
      while (k < 100 && dn == 0) begin
         @(negedge clk);
         k++;
         start = 1'b0;
         if (ev_if.ev_req) st++;
         if (done) dn = 1;
      end
      check_eq("tmo/done_seen", dn, 1);
      check_eq("tmo/req_cycles", st, 4);
      check_eq("tmo/status", status, 3);
      check_eq("tmo/root", root, 0);
      ack_off = 1'b0;
      $display("run timeout req_cycles=%0d status=%0d root=%h", st, status, root);
      @(negedge clk);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bisection_seq.md
Name: bisection_seq

Overview:
- Control FSM that runs a bisection root search over a shared polynomial evaluator.
- Owns the bracket registers a/b, the midpoint, the iteration counter and the termination tests.
- Requests each f(x) through a req/ack port, so one evaluator (multi-cycle Horner/power chain) serves this block and other requesters through an external arbiter.
- Fixed point throughout: signed two's complement, 20 bits, 15 fractional bits (Q4.15).

Parameters:
- W, 20, data width of x, f(x), tol, root.
- FRAC, 15, fractional bits; informational only, no scaling is done in this block.
- ITER_W, 6, width of max_iter and iter_count.
- ACK_TIMEOUT, 255, cycles ev_req may wait for ev_ack; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- start  in  1  one-cycle request; sampled only in IDLE.
- a_init  in  W  lower bracket, signed.
- b_init  in  W  upper bracket, signed; a_init < b_init required.
- tol  in  W  convergence threshold on |f(c)|, unsigned magnitude.
- max_iter  in  ITER_W  iteration budget; 0 treated as 1.
- busy  out  1  high from the cycle after an accepted start through DONE.
- done  out  1  one-cycle pulse in DONE.
- root  out  W  final midpoint.
- iter_count  out  ITER_W  midpoints evaluated.
- status  out  2  00 CONVERGED, 01 MAX_ITER, 10 NO_BRACKET, 11 EV_TIMEOUT.
- ev_req  out  1  evaluation request.
- ev_x  out  W  abscissa to evaluate.
- ev_ack  in  1  evaluator result valid, one cycle.
- ev_fx  in  W  f(ev_x), signed.

Behaviour:
- Reset values: all outputs 0, internal registers 0, state IDLE. Reset mid-operation aborts immediately; no done pulse.
- Start latch: start in IDLE latches a_init, b_init, tol, max_iter. Inputs are not re-sampled during the run. start is ignored while busy.
- States: IDLE -> EVAL_A -> EVAL_B -> CHECK -> MID -> EVAL_C -> DECIDE -> (MID or DONE) -> IDLE.
- Evaluation handshake (EVAL_*):
  - ev_req=1 with ev_x stable until ev_ack is sampled high.
  - ev_fx is captured that cycle; ev_req drops the next cycle.
  - ev_ack while ev_req=0 is ignored.
  - ev_ack in the first request cycle is legal, giving a minimum of 1 cycle per evaluation.
- CHECK:
  - fa==0 -> root=a, CONVERGED, iter 0.
  - Else fb==0 -> root=b, CONVERGED, iter 0.
  - Else sign(fa)==sign(fb) -> NO_BRACKET, root=0.
  - Else go to MID.
- MID: c = (a+b)>>>1, computed as a (W+1)-bit sign-extended sum then arithmetic shift, so no overflow.
- EVAL_C: evaluate c; iter_count += 1 on capture.
- DECIDE, in priority order:
  - |fc| <= tol -> CONVERGED.
  - Else iter_count == max(max_iter,1) -> MAX_ITER.
  - Else sign(fc) != sign(fa): b=c, fb=fc. Otherwise: a=c, fa=fc. Then go to MID.
  - Abs: |-2^(W-1)| saturates to 2^(W-1)-1.
- DONE: root=c (except the CHECK paths above); done=1 for one cycle; busy drops next cycle.
- root, status, iter_count hold until the next accepted start, which clears iter_count.
- Latency with 1-cycle ack:
  - Exact first-midpoint hit: start to done = 8 cycles.
  - Each further iteration adds 3 cycles.

Optional Feature:
- Macro: BISECT_ACK_TIMEOUT_EN.
- Defined:
  - A counter runs while ev_req is high.
  - If ACK_TIMEOUT cycles pass without ev_ack: drop ev_req, status=EV_TIMEOUT, root=current c (0 if in EVAL_A/B), go to DONE.
  - Counter clears on each new request.
- Undefined: no counter; the FSM waits for ev_ack indefinitely; status 11 is never produced.

Decomposition:
- Package bisection_pkg:
  - W, FRAC, ITER_W defaults.
  - status codes ST_CONVERGED/ST_MAX_ITER/ST_NO_BRACKET/ST_EV_TIMEOUT.
  - FSM state enum.
  - Q4.15 constants ONE=0x08000, HALF=0x04000.
- Sub-module bisection_step, combinational:
  - Inputs a, b, fa, fc.
  - Outputs next a, next b, midpoint, |fc| with saturation.
  - Keeps the FSM free of arithmetic.

Test Plan:
- Exact-hit: bench evaluator f(x)=x-HALF with ack after 1 cycle; a=0x00000, b=0x08000, tol=0, max_iter=10 -> done 8 cycles after start; root=0x04000, iter_count=1, status=00.
- Narrowing: same f; a=0x03C00, b=0x05000, tol=0x00010, max_iter=20 -> midpoints in order 0x04600, 0x04100, 0x03E80, 0x03FC0, 0x04060, ...; stops at first |c-0x04000|<=0x10; status=00.
- Budget: same as Narrowing but tol=0, max_iter=3 -> status=01, iter_count=3, root=0x03E80.
- No bracket: f(x)=x+HALF, a=0x00000, b=0x08000 -> status=10, iter_count=0, exactly 2 evaluations requested.
- Handshake/reset:
  - Random ack delays 0-7 cycles: ev_x stable while ev_req is high; the result matches the zero-delay run.
  - Assert reset while in EVAL_C: next cycle ev_req=0, busy=0, no done pulse.
  - start while busy is ignored.
- Timeout (BISECT_ACK_TIMEOUT_EN, ACK_TIMEOUT=4): ev_ack never asserted -> done after 4 request cycles in EVAL_A, status=11, root=0.
